// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD bus sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_INIT  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_WAIT  = 3'd5,
        ST_IDLE  = 3'd6
    } lcd_state_e;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_xfer_t;

    localparam int unsigned INIT_LEN      = 7;
    localparam int unsigned IDX_W         = 3;
    localparam logic        RS_CMD        = 1'b0;
    localparam logic        RS_DATA       = 1'b1;
    localparam logic [7:0]  CLR_HOME_MASK = 8'hFC;

    function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h38;
            3'd4:             return 8'h0C;
            3'd5:             return 8'h01;
            3'd6:             return 8'h06;
            default:          return 8'h00;
        endcase
    endfunction

    // Clear and return-home commands need the long busy interval.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return (rs == RS_CMD) && ((b & CLR_HOME_MASK) == 8'h00);
    endfunction

    function automatic int unsigned max5(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d,
                                         input int unsigned e);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter; done is high in the last cycle of an N-cycle interval loaded with N.
module lcd_wait_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_cnt;

    // Parent holds i_load during reset, so the count needs no reset of its own.
    always_ff @(posedge clk) begin
        if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/lcd_bus_sequencer.sv
// HD44780 bus sequencer: power-on init, then round-robin byte writes from two requesters.
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 750000,
    parameter int unsigned T_AS    = 2,
    parameter int unsigned T_EN    = 12,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLR   = 82000
) (
    input  logic       FiftyM_clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       rs_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic       rs_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    output logic       ready,
    output logic [7:0] DB,
    output logic       RS,
    output logic       RW,
    output logic       EN
);

    localparam int unsigned CNT_W = $clog2(max5(T_PWRUP, T_AS, T_EN, T_CMD, T_CLR)) + 1;

    lcd_state_e       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_rr_b, w_rr_b_nxt;
    lcd_xfer_t        r_xfer, w_xfer_nxt;
    logic             r_en, w_en_nxt;
    logic             r_ready, w_ready_nxt;
    logic             r_ack_a, w_ack_a_nxt;
    logic             r_ack_b, w_ack_b_nxt;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_done;
    logic             w_gnt_a, w_gnt_b;

    lcd_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (FiftyM_clk),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done_c   (w_tmr_done)
    );

    // On a tie the requester that is not the pointer wins.
    assign w_gnt_a = req_a && (!req_b || r_rr_b);
    assign w_gnt_b = req_b && (!req_a || !r_rr_b);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rr_b_nxt  = r_rr_b;
        w_xfer_nxt  = r_xfer;
        w_ack_a_nxt = 1'b0;
        w_ack_b_nxt = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        if (!rst) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = CNT_W'(T_PWRUP);
        end else begin
            case (r_state)
                ST_PWRUP: begin
                    if (w_tmr_done) w_state_nxt = ST_INIT;
                end
                ST_INIT: begin
                    w_xfer_nxt.rs   = RS_CMD;
                    w_xfer_nxt.data = init_rom(r_idx);
                    w_state_nxt     = ST_SETUP;
                    w_tmr_load      = 1'b1;
                    w_tmr_val       = CNT_W'(T_AS);
                end
                ST_SETUP: begin
                    if (w_tmr_done) begin
                        w_state_nxt = ST_PULSE;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = CNT_W'(T_EN);
                    end
                end
                ST_PULSE: begin
                    if (w_tmr_done) w_state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    w_state_nxt = ST_WAIT;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = is_long_cmd(r_xfer.rs, r_xfer.data) ? CNT_W'(T_CLR)
                                                                      : CNT_W'(T_CMD);
                end
                ST_WAIT: begin
                    if (w_tmr_done) begin
                        if (r_idx < IDX_W'(INIT_LEN)) w_idx_nxt = r_idx + IDX_W'(1);
                        w_state_nxt = (w_idx_nxt < IDX_W'(INIT_LEN)) ? ST_INIT : ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_gnt_a) begin
                        w_xfer_nxt.rs   = rs_a;
                        w_xfer_nxt.data = data_a;
                        w_ack_a_nxt     = 1'b1;
                    end else if (w_gnt_b) begin
                        w_xfer_nxt.rs   = rs_b;
                        w_xfer_nxt.data = data_b;
                        w_ack_b_nxt     = 1'b1;
                    end
                    if (req_a && req_b) w_rr_b_nxt = w_gnt_b;
                    if (w_gnt_a || w_gnt_b) begin
                        w_state_nxt = ST_SETUP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = CNT_W'(T_AS);
                    end
                end
                default: w_state_nxt = ST_PWRUP;
            endcase
        end
        w_en_nxt    = (w_state_nxt == ST_PULSE);
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge FiftyM_clk) begin
        if (!rst) begin
            r_state <= ST_PWRUP;
            r_idx   <= '0;
            r_rr_b  <= 1'b1;
            r_xfer  <= '0;
            r_en    <= 1'b0;
            r_ready <= 1'b0;
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_rr_b  <= w_rr_b_nxt;
            r_xfer  <= w_xfer_nxt;
            r_en    <= w_en_nxt;
            r_ready <= w_ready_nxt;
            r_ack_a <= w_ack_a_nxt;
            r_ack_b <= w_ack_b_nxt;
        end
    end

    assign DB    = r_xfer.data;
    assign RS    = r_xfer.rs;
    assign RW    = 1'b0;
    assign EN    = r_en;
    assign ready = r_ready;
    assign ack_a = r_ack_a;
    assign ack_b = r_ack_b;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Scoreboard bench for lcd_bus_sequencer: a transaction-level schedule model feeds expected
// acks, EN pulses and ready rises; independent monitors compare what the bus shows.
module tb_lcd_bus_sequencer;

    localparam int P_PWRUP = 20;
    localparam int P_AS    = 2;
    localparam int P_EN    = 3;
    localparam int P_CMD   = 10;
    localparam int P_CLR   = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_a = 1'b0, rs_a = 1'b0, req_b = 1'b0, rs_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic       ack_a, ack_b, ready, RS, RW, EN;
    logic [7:0] DB;

    always #5 clk = ~clk;

    lcd_bus_sequencer #(
        .T_PWRUP (P_PWRUP), .T_AS (P_AS), .T_EN (P_EN), .T_CMD (P_CMD), .T_CLR (P_CLR)
    ) dut (
        .FiftyM_clk (clk),    .rst    (rst),
        .req_a      (req_a),  .rs_a   (rs_a),  .data_a (data_a), .ack_a (ack_a),
        .req_b      (req_b),  .rs_b   (rs_b),  .data_b (data_b), .ack_b (ack_b),
        .ready      (ready),  .DB     (DB),    .RS     (RS),     .RW    (RW),
        .EN         (EN)
    );

    typedef struct { logic rs; logic [7:0] db; int cyc; } wr_t;
    typedef struct { bit is_b; int cyc; } ack_t;

    wr_t  exp_wr[$];
    ack_t exp_ack[$];
    int   exp_rdy[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] init_bytes [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};

    // Cycle index since reset release: 0 in the cycle after the last reset edge.
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s @cyc %0d: event seen, none required", name, cyc);
    endtask

    function automatic int busy(input logic rs, input logic [7:0] d);
        return (rs == 1'b0 && d < 8'd4) ? P_CLR : P_CMD;
    endfunction

    // ---------------- monitors ----------------
    bit         en_prev = 0, rdy_prev = 0;
    int         en_len = 0;
    wr_t        mw;
    ack_t       ma;
    int         mr;
    logic       cur_rs;
    logic [7:0] cur_db;

    always @(negedge clk) begin
        if (!rst) begin
            en_prev = 0;
            en_len  = 0;
        end else begin
            if (EN && !en_prev) begin
                if (exp_wr.size() == 0) fail_evt("unexpected_en");
                else begin
                    mw = exp_wr.pop_front();
                    chk("en_rise_cycle", cyc, mw.cyc);
                    chk("en_db", int'(DB), int'(mw.db));
                    chk("en_rs", int'(RS), int'(mw.rs));
                    cur_rs = mw.rs;
                    cur_db = mw.db;
                end
                en_len = 1;
            end else if (EN) begin
                en_len++;
                chk("en_bus_hold", int'({RS, DB}), int'({cur_rs, cur_db}));
            end else if (en_prev) begin
                chk("en_width", en_len, P_EN);
            end
            en_prev = EN;
        end
    end

    always @(negedge clk) begin
        if (!rst) rdy_prev = 0;
        else begin
            if (ready && !rdy_prev) begin
                if (exp_rdy.size() == 0) fail_evt("unexpected_ready");
                else begin
                    mr = exp_rdy.pop_front();
                    chk("ready_rise_cycle", cyc, mr);
                end
            end
            rdy_prev = ready;
        end
    end

    always @(negedge clk) begin
        if (rst && (ack_a || ack_b)) begin
            chk("ack_overlap", int'(ack_a && ack_b), 0);
            chk("ready_at_ack", int'(ready), 0);
            if (exp_ack.size() == 0) fail_evt("unexpected_ack");
            else begin
                ma = exp_ack.pop_front();
                chk("ack_src_is_b", int'(ack_b), int'(ma.is_b));
                chk("ack_cycle", cyc, ma.cyc);
            end
        end
    end

    // ---------------- reference model and stimulus ----------------
    int         t_idle;
    bit         pend_a = 0, pend_b = 0, rr_b = 1;
    logic       pa_rs = 1'b0, pb_rs = 1'b0;
    logic [7:0] pa_d = 8'h00, pb_d = 8'h00;

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold reset across two edges, check reset outputs, release and schedule the init writes.
    task automatic do_reset();
        int t;
        rst = 1'b0;
        exp_wr.delete();
        exp_ack.delete();
        exp_rdy.delete();
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({DB, RS, RW, EN, ack_a, ack_b, ready}), 0);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        rr_b = 1;
        t    = P_PWRUP;
        for (int i = 0; i < 7; i++) begin
            t += 1;
            exp_wr.push_back('{rs: 1'b0, db: init_bytes[i], cyc: t + P_AS});
            t += P_AS + P_EN + 1 + busy(1'b0, init_bytes[i]);
        end
        exp_rdy.push_back(P_PWRUP + 7 * (P_AS + P_EN + 1) + 6 * P_CMD + P_CLR + 7);
        t_idle = t;
    endtask

    // One grant: optionally raise new requests, predict the winner and its bus timing.
    task automatic round(input bit ra, input logic rsa, input logic [7:0] da,
                         input bit rb, input logic rsb, input logic [7:0] dbb,
                         input int dly, output int g_o);
        int         d, g;
        bit         win_b;
        logic       wrs;
        logic [7:0] wd;
        if (!pend_a && !pend_b && !ra && !rb) ra = 1;
        d = (pend_a || pend_b) ? 0 : dly;
        if (ra && !pend_a) begin pend_a = 1; pa_rs = rsa; pa_d = da; end
        if (rb && !pend_b) begin pend_b = 1; pb_rs = rsb; pb_d = dbb; end
        g = t_idle + d;
        wait_cyc((d == 0) ? t_idle - 1 : g);
        req_a = pend_a; rs_a = pa_rs; data_a = pa_d;
        req_b = pend_b; rs_b = pb_rs; data_b = pb_d;
        if (pend_a && pend_b) begin
            win_b = !rr_b;
            rr_b  = win_b;
        end else begin
            win_b = pend_b;
        end
        wrs = win_b ? pb_rs : pa_rs;
        wd  = win_b ? pb_d  : pa_d;
        exp_ack.push_back('{is_b: win_b, cyc: g + 1});
        exp_wr.push_back('{rs: wrs, db: wd, cyc: g + 1 + P_AS});
        t_idle = g + 1 + P_AS + P_EN + 1 + busy(wrs, wd);
        exp_rdy.push_back(t_idle);
        if (win_b) pend_b = 0; else pend_a = 0;
        wait_cyc(g + 2);
        if (win_b) req_b = 1'b0; else req_a = 1'b0;
        g_o = g;
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 3));
        return 8'($urandom);
    endfunction

    initial begin
        int g;
        do_reset();

        // Request raised during init must wait for the first IDLE cycle.
        wait_cyc(40);
        req_a = 1'b1; rs_a = 1'b1; data_a = 8'h41;
        pend_a = 1; pa_rs = 1'b1; pa_d = 8'h41;
        round(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, g);

        round(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 0, g);
        round(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 2, g);

        // Both requesting back to back: grants alternate starting with A.
        for (int i = 0; i < 4; i++)
            round(1'b1, 1'($urandom_range(0, 1)), rand_byte(),
                  1'b1, 1'($urandom_range(0, 1)), rand_byte(), 0, g);

        for (int i = 0; i < 20; i++)
            round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_byte(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_byte(),
                  int'($urandom_range(1, 4)), g);
        if (pend_a || pend_b) round(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, g);

        // Reset in the middle of an EN pulse; B keeps requesting through reset and init.
        round(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 0, g);
        wait_cyc(g + 2 + P_AS);
        chk("en_before_reset", int'(EN), 1);
        req_a = 1'b0;
        req_b = 1'b1; rs_b = 1'b0; data_b = 8'h02;
        pend_b = 1; pb_rs = 1'b0; pb_d = 8'h02;
        do_reset();
        round(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, g);
        round(1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h7E, 0, g);
        if (pend_a || pend_b) round(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0, g);

        wait_cyc(t_idle + 3);
        chk("leftover_en", exp_wr.size(), 0);
        chk("leftover_ack", exp_ack.size(), 0);
        chk("leftover_ready", exp_rdy.size(), 0);
        chk("ready_final", int'(ready), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        fail_evt("watchdog_timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
